// File: rtl/subcore_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : subcore_mem_arbiter_if
//  Purpose  : Bundle of the request/response handshake and the memory-side
//             bus used by subcore_mem_arbiter.
//  Ports    : (signals)
//             req_valid/req_ready/req_addr/req_din/req_we  - requester side
//             resp_valid/resp_dout                         - read return
//             mem_en/mem_we/mem_addr/mem_din/mem_dout      - shared BRAM
//             err_oob                                      - sticky range error
//  Modports : slave  - arbiter view
//             master - requesters + memory view (testbench / integration)
//  Revision : 1.0  initial release
// ============================================================================
interface subcore_mem_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_ready;
    logic [NUM_PORTS*32-1:0]     req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_din;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS-1:0]        resp_valid;
    logic [DATA_W-1:0]           resp_dout;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_din;
    logic [DATA_W-1:0]           mem_dout;
    logic                        err_oob;

    modport slave (
        input  req_valid, req_addr, req_din, req_we, mem_dout,
        output req_ready, resp_valid, resp_dout,
               mem_en, mem_we, mem_addr, mem_din, err_oob
    );

    modport master (
        output req_valid, req_addr, req_din, req_we, mem_dout,
        input  req_ready, resp_valid, resp_dout,
               mem_en, mem_we, mem_addr, mem_din, err_oob
    );
endinterface
`default_nettype wire

// File: rtl/subcore_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : subcore_mem_arbiter
//  Purpose  : Round-robin arbiter sharing one single-port data memory among
//             NUM_PORTS requesters. At most one access is granted per cycle;
//             each load is tagged with its port and its data is returned to
//             that port MEM_LATENCY cycles after the grant.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous, active-high reset
//             bus  - subcore_mem_arbiter_if.slave (requests, responses,
//                    memory strobes, err_oob)
//  Options  : MEM_ARB_BOUNDS_EN - when defined, accesses at or above DEPTH are
//             consumed without touching memory, loads return zero and err_oob
//             latches. When undefined the address is simply truncated.
//  Revision : 1.0  initial release
// ============================================================================
module subcore_mem_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int DEPTH       = 131072,
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    subcore_mem_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // ------------------------------------------------------------------------
    // Arbitration: winner index and "any grant" flag
    // ------------------------------------------------------------------------
    logic             w_found;
    logic [PTR_W-1:0] w_win;

    generate
        if (NUM_PORTS == 1) begin : g_single
            // Single requester: pointer is constant zero, grant follows valid.
            assign w_found = bus.req_valid[0] & ~rst;
            assign w_win   = '0;
        end else begin : g_rr
            logic [PTR_W-1:0]     r_ptr;
            logic [NUM_PORTS-1:0] w_rot;
            logic [PTR_W-1:0]     w_off;
            logic                 w_any;
            logic [PTR_W:0]       w_sum;

            always_comb begin
                // Rotate so bit 0 is the port at the pointer; the first set
                // bit then gives the offset of the winner from the pointer.
                w_rot = NUM_PORTS'({bus.req_valid, bus.req_valid} >> r_ptr);
                w_any = 1'b0;
                w_off = '0;
                for (int j = NUM_PORTS - 1; j >= 0; j--) begin
                    if (w_rot[j]) begin
                        w_any = 1'b1;
                        w_off = PTR_W'(j);
                    end
                end
                w_sum = {1'b0, r_ptr} + {1'b0, w_off};
                if (w_sum >= (PTR_W+1)'(NUM_PORTS)) begin
                    w_sum = w_sum - (PTR_W+1)'(NUM_PORTS);
                end
            end

            // No grants while reset is held, so nothing is consumed then.
            assign w_found = w_any & ~rst;
            assign w_win   = w_sum[PTR_W-1:0];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_found) begin
                    r_ptr <= (w_win == PTR_W'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Grant vector and winner request mux
    // ------------------------------------------------------------------------
    logic [NUM_PORTS-1:0] w_grant;
    logic [31:0]          w_addr32;
    logic [DATA_W-1:0]    w_din;
    logic                 w_we;

    always_comb begin
        w_grant  = '0;
        w_addr32 = '0;
        w_din    = '0;
        w_we     = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_grant[i] = w_found && (w_win == PTR_W'(i));
            if (w_grant[i]) begin
                w_addr32 = bus.req_addr[32*i +: 32];
                w_din    = bus.req_din[DATA_W*i +: DATA_W];
                w_we     = bus.req_we[i];
            end
        end
    end

    assign bus.req_ready = w_grant;

    // ------------------------------------------------------------------------
    // Range check
    // ------------------------------------------------------------------------
    logic w_oob;

`ifdef MEM_ARB_BOUNDS_EN
    logic r_err_oob;

    assign w_oob = w_found && (w_addr32 >= 32'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_oob <= 1'b0;
        end else if (w_oob) begin
            r_err_oob <= 1'b1;
        end
    end

    assign bus.err_oob = r_err_oob;
`else
    // Upper address bits are deliberately dropped in this build.
    logic w_unused_addr_hi;

    assign w_oob            = 1'b0;
    assign w_unused_addr_hi = ^w_addr32[31:ADDR_W];
    assign bus.err_oob      = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Memory drive
    // ------------------------------------------------------------------------
    assign bus.mem_en   = w_found & ~w_oob;
    assign bus.mem_we   = w_found & w_we & ~w_oob;
    assign bus.mem_addr = w_addr32[ADDR_W-1:0];
    assign bus.mem_din  = w_din;

    // ------------------------------------------------------------------------
    // Read tag pipeline: one stage per cycle of memory latency. Stage 0 is
    // loaded at the grant edge, so the last stage is valid exactly in the
    // cycle the memory presents the data.
    // ------------------------------------------------------------------------
    logic [MEM_LATENCY-1:0] r_tag_v;
    logic [MEM_LATENCY-1:0] r_tag_oob;
    logic [PTR_W-1:0]       r_tag_port [MEM_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_v   <= '0;
            r_tag_oob <= '0;
            for (int s = 0; s < MEM_LATENCY; s++) begin
                r_tag_port[s] <= '0;
            end
        end else begin
            r_tag_v[0]    <= w_found & ~w_we;
            r_tag_oob[0]  <= w_oob;
            r_tag_port[0] <= w_win;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                r_tag_v[s]    <= r_tag_v[s-1];
                r_tag_oob[s]  <= r_tag_oob[s-1];
                r_tag_port[s] <= r_tag_port[s-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response return
    // ------------------------------------------------------------------------
    always_comb begin
        bus.resp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.resp_valid[i] = r_tag_v[MEM_LATENCY-1] &&
                                (r_tag_port[MEM_LATENCY-1] == PTR_W'(i));
        end
        // Out-of-range loads never read memory, so their data is forced to 0.
        bus.resp_dout = (r_tag_v[MEM_LATENCY-1] && !r_tag_oob[MEM_LATENCY-1]) ?
                        bus.mem_dout : '0;
    end

endmodule
`default_nettype wire
